// File: rtl/lock_pkg.sv
// Shared definitions for the canal-lock operator sequencer: state encoding,
// direction codes, default timeout limits and a small state-class helper.
package lock_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PREP,
    ST_OPEN_IN,
    ST_WAIT_IN,
    ST_CLOSE_IN,
    ST_ADJ,
    ST_OPEN_OUT,
    ST_WAIT_OUT,
    ST_CLOSE_OUT,
    ST_DONE,
    ST_FAULT
  } lockState_t;

  localparam logic DIR_ARR2DEPT = 1'b0;
  localparam logic DIR_DEPT2ARR = 1'b1;

  localparam int DEF_LVL_W        = 4;
  localparam int DEF_LVL_TIMEOUT  = 32;
  localparam int DEF_GATE_TIMEOUT = 8;
  localparam int DEF_BOAT_TIMEOUT = 64;

  // Width of the per-state cycle counter; comfortably above any sane timeout.
  localparam int CNT_W = 16;

  // True for the four states that open or close a gate with a gateCtrl pulse.
  function automatic logic isGateState(input lockState_t s);
    return (s == ST_OPEN_IN) || (s == ST_CLOSE_IN) ||
           (s == ST_OPEN_OUT) || (s == ST_CLOSE_OUT);
  endfunction

endpackage

// File: rtl/level_matcher.sv
// Unsigned comparison of the pound level against the current target level.
module level_matcher #(
  parameter int LVL_W = 4
) (
  input  logic [LVL_W-1:0] insideLvl,
  input  logic [LVL_W-1:0] targetLvl,
  output logic             raise,
  output logic             lower,
  output logic             atLevel
);

  // Exactly one of raise/lower/atLevel is high for any pair of levels.
  always_comb begin
    raise   = (insideLvl < targetLvl);
    lower   = (insideLvl > targetLvl);
    atLevel = (insideLvl == targetLvl);
  end

endmodule

// File: rtl/lock_sequencer.sv
// Automatic operator for the canal lock: walks a boat through the lock by
// driving level-adjust and gate commands and watching the lock status.
// Optional build macro LOCK_SEQ_PASS_CNT_EN adds an 8-bit completed-passage
// counter output passCount.
module lock_sequencer
  import lock_pkg::*;
#(
  parameter int LVL_W        = DEF_LVL_W,
  parameter int LVL_TIMEOUT  = DEF_LVL_TIMEOUT,
  parameter int GATE_TIMEOUT = DEF_GATE_TIMEOUT,
  parameter int BOAT_TIMEOUT = DEF_BOAT_TIMEOUT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req,
  input  logic             dir,
  input  logic [LVL_W-1:0] arrivOutsideLvl,
  input  logic [LVL_W-1:0] deptOutsideLvl,
  input  logic [LVL_W-1:0] insideWaterLvl,
  input  logic             arrivGate,
  input  logic             deptGate,
  input  logic             poundOccupied,
  output logic             incr,
  output logic             decr,
  output logic             gateCtrl,
  output logic             fiveMinTillArrival,
  output logic             busy,
  output logic             done,
  output logic             fault
`ifdef LOCK_SEQ_PASS_CNT_EN
  ,
  output logic [7:0]       passCount
`endif
);

  localparam logic [CNT_W-1:0] LVL_LIM  = CNT_W'(LVL_TIMEOUT);
  localparam logic [CNT_W-1:0] GATE_LIM = CNT_W'(GATE_TIMEOUT);
  localparam logic [CNT_W-1:0] BOAT_LIM = CNT_W'(BOAT_TIMEOUT);

  lockState_t       r_state;
  lockState_t       w_stateNext;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_limit;
  logic             w_expired;
  logic             w_firstCycle;
  logic             r_dir;
  logic [LVL_W-1:0] r_entryLvl;
  logic [LVL_W-1:0] r_exitLvl;
  logic [LVL_W-1:0] w_target;
  logic             w_raise;
  logic             w_lower;
  logic             w_atLevel;
  logic             w_entryGate;
  logic             w_exitGate;
  logic             w_adjusting;
  logic             r_incr;
  logic             r_decr;
  logic             r_gateCtrl;
  logic             r_five;
  logic             w_incrNext;
  logic             w_decrNext;
  logic             w_gateNext;
  logic             w_fiveNext;

  assign w_target    = (r_state == ST_PREP) ? r_entryLvl : r_exitLvl;
  assign w_entryGate = (r_dir == DIR_DEPT2ARR) ? deptGate : arrivGate;
  assign w_exitGate  = (r_dir == DIR_DEPT2ARR) ? arrivGate : deptGate;

  level_matcher #(.LVL_W(LVL_W)) u_matcher (
    .insideLvl (insideWaterLvl),
    .targetLvl (w_target),
    .raise     (w_raise),
    .lower     (w_lower),
    .atLevel   (w_atLevel)
  );

  // Pick the timeout that applies to the current state; zero means no limit.
  always_comb begin
    w_limit = '0;
    case (r_state)
      ST_PREP, ST_ADJ:           w_limit = LVL_LIM;
      ST_WAIT_IN, ST_WAIT_OUT:   w_limit = BOAT_LIM;
      ST_OPEN_IN, ST_CLOSE_IN,
      ST_OPEN_OUT, ST_CLOSE_OUT: w_limit = GATE_LIM;
      default:                   w_limit = '0;
    endcase
    w_expired    = (w_limit != '0) && (r_cnt >= (w_limit - 1'b1));
    w_firstCycle = (r_cnt == '0);
  end

  // Next-state logic; gate feedback is ignored in the pulse cycle so the lock
  // has a cycle to react, and a met condition wins over a same-cycle timeout.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_IDLE:      if (req) w_stateNext = ST_PREP;
      ST_PREP:      if (w_atLevel) w_stateNext = ST_OPEN_IN;
                    else if (w_expired) w_stateNext = ST_FAULT;
      ST_OPEN_IN:   if (!w_firstCycle && w_entryGate) w_stateNext = ST_WAIT_IN;
                    else if (w_expired) w_stateNext = ST_FAULT;
      ST_WAIT_IN:   if (poundOccupied) w_stateNext = ST_CLOSE_IN;
                    else if (w_expired) w_stateNext = ST_FAULT;
      ST_CLOSE_IN:  if (!w_firstCycle && !w_entryGate) w_stateNext = ST_ADJ;
                    else if (w_expired) w_stateNext = ST_FAULT;
      ST_ADJ:       if (w_atLevel) w_stateNext = ST_OPEN_OUT;
                    else if (w_expired) w_stateNext = ST_FAULT;
      ST_OPEN_OUT:  if (!w_firstCycle && w_exitGate) w_stateNext = ST_WAIT_OUT;
                    else if (w_expired) w_stateNext = ST_FAULT;
      ST_WAIT_OUT:  if (!poundOccupied) w_stateNext = ST_CLOSE_OUT;
                    else if (w_expired) w_stateNext = ST_FAULT;
      ST_CLOSE_OUT: if (!w_firstCycle && !w_exitGate) w_stateNext = ST_DONE;
                    else if (w_expired) w_stateNext = ST_FAULT;
      ST_DONE:      w_stateNext = ST_IDLE;
      ST_FAULT:     w_stateNext = ST_FAULT;
      default:      w_stateNext = ST_IDLE;
    endcase

    w_adjusting = ((r_state == ST_PREP) || (r_state == ST_ADJ)) && (w_stateNext == r_state);
    w_incrNext  = w_adjusting && w_raise;
    w_decrNext  = w_adjusting && w_lower;
    w_gateNext  = isGateState(w_stateNext) && (w_stateNext != r_state);
    w_fiveNext  = (w_stateNext == ST_PREP) || (w_stateNext == ST_OPEN_IN) ||
                  (w_stateNext == ST_WAIT_IN);
  end

  // State register, per-state counter, latched passage targets and registered commands.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_dir      <= DIR_ARR2DEPT;
      r_entryLvl <= '0;
      r_exitLvl  <= '0;
      r_incr     <= 1'b0;
      r_decr     <= 1'b0;
      r_gateCtrl <= 1'b0;
      r_five     <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_incr     <= w_incrNext;
      r_decr     <= w_decrNext;
      r_gateCtrl <= w_gateNext;
      r_five     <= w_fiveNext;
      if ((w_stateNext != r_state) || (r_state == ST_IDLE) || (r_state == ST_FAULT)) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if ((r_state == ST_IDLE) && req) begin
        r_dir      <= dir;
        r_entryLvl <= (dir == DIR_DEPT2ARR) ? deptOutsideLvl : arrivOutsideLvl;
        r_exitLvl  <= (dir == DIR_DEPT2ARR) ? arrivOutsideLvl : deptOutsideLvl;
      end
    end
  end

  assign incr               = r_incr;
  assign decr               = r_decr;
  assign gateCtrl           = r_gateCtrl;
  assign fiveMinTillArrival = r_five;
  assign busy               = (r_state != ST_IDLE);
  assign done               = (r_state == ST_DONE);
  assign fault              = (r_state == ST_FAULT);

`ifdef LOCK_SEQ_PASS_CNT_EN
  logic [7:0] r_passCount;

  // Count completed passages, wrapping at 256 and holding while faulted.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_passCount <= 8'd0;
    end else if (done && !fault) begin
      r_passCount <= r_passCount + 8'd1;
    end
  end

  assign passCount = r_passCount;
`endif

endmodule

// File: doc/lock_sequencer.md
Name: lock_sequencer

Overview:
- Automatic operator stage directly upstream of the canal-lock controller (`overall`).
- Accepts a boat passage request (arrival->departure or departure->arrival) and issues the lock's command inputs in order: fiveMinTillArrival, incr, decr, gateCtrl.
- Closes the loop on the lock's status outputs: insideWaterLvl, arrivGate, deptGate, poundOccupied.
- Reports busy/done/fault to the supervisory logic.

Parameters:
- LVL_W, 4, width of all water-level buses.
- LVL_TIMEOUT, 32, max cycles allowed in a level-adjust state before fault.
- GATE_TIMEOUT, 8, max cycles allowed after a gateCtrl pulse for the expected gate change.
- BOAT_TIMEOUT, 64, max cycles waiting for poundOccupied to change.

Ports:
- clock  in  1  system clock, all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- req  in  1  passage request, sampled in IDLE only.
- dir  in  1  direction, sampled with req: 0 = arrival->departure, 1 = departure->arrival.
- arrivOutsideLvl  in  LVL_W  water level on the arrival side.
- deptOutsideLvl  in  LVL_W  water level on the departure side.
- insideWaterLvl  in  LVL_W  pound level from the lock.
- arrivGate  in  1  arrival gate open (1) / closed (0).
- deptGate  in  1  departure gate open (1) / closed (0).
- poundOccupied  in  1  boat in pound.
- incr  out  1  raise pound level to the lock.
- decr  out  1  lower pound level to the lock.
- gateCtrl  out  1  one-cycle gate toggle command to the lock.
- fiveMinTillArrival  out  1  arrival warning to the lock.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a passage completes.
- fault  out  1  sticky timeout indication.

Behaviour:
- Reset (reset==0 at a clock edge):
  - All outputs go to 0; state goes to IDLE; all counters clear.
  - Applies mid-operation with the same result; the lock is left as-is.
- Targets are latched at req acceptance:
  - dir=0: entry level = arrivOutsideLvl, exit level = deptOutsideLvl.
  - dir=1: the two are swapped.
  - Entry gate = arrivGate if dir=0, else deptGate.
- Level adjust (registered outputs):
  - incr=1 when insideWaterLvl < target; decr=1 when insideWaterLvl > target.
  - Never both high; both 0 at match or outside adjust states.
  - Comparison is unsigned on LVL_W bits.
- State transitions:
  - IDLE: req=1 -> PREP. req while busy is ignored, not queued.
  - PREP: fiveMinTillArrival=1, adjust to the entry level. Match -> OPEN_IN.
  - OPEN_IN: pulse gateCtrl one cycle, then wait for entry gate = 1 -> WAIT_IN.
  - WAIT_IN: wait for poundOccupied=1 -> CLOSE_IN. fiveMinTillArrival drops on exit from this state.
  - CLOSE_IN: pulse gateCtrl, wait for entry gate = 0 -> ADJ.
  - ADJ: adjust to the exit level. Match -> OPEN_OUT.
  - OPEN_OUT: pulse gateCtrl, wait for exit gate = 1 -> WAIT_OUT.
  - WAIT_OUT: wait for poundOccupied=0 -> CLOSE_OUT.
  - CLOSE_OUT: pulse gateCtrl, wait for exit gate = 0 -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- gateCtrl pulse timing: issued in the first cycle of its state only; never re-pulsed while waiting.
- Already-matched level on entry to PREP or ADJ: advances the next cycle with no incr/decr.
- Timeouts:
  - The per-state counter clears on every state change.
  - Reaching the applicable timeout -> FAULT.
  - FAULT: incr=decr=gateCtrl=fiveMinTillArrival=0, fault=1, busy=1. Exited only by reset.
- Gate already in the target state when a gate state is entered: still pulse gateCtrl, then apply GATE_TIMEOUT. A gate that never reaches the target state faults; no special case is permitted.

Optional Feature:
- Macro: LOCK_SEQ_PASS_CNT_EN.
- Defined:
  - Adds output passCount [7:0], cleared on reset.
  - Increments on each done pulse, wraps 255->0.
  - Frozen while fault=1.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared package lock_pkg holds:
  - the state encoding enum;
  - DIR_ARR2DEPT=0 and DIR_DEPT2ARR=1;
  - default timeout constants.
- One sub-module, level_matcher:
  - combinational compare of inside vs target;
  - outputs raise, lower, atLevel;
  - instantiated once with the target muxed by state.

Test Plan:
- Reset held 2 cycles, then released with req=0 -> all outputs 0, busy=0.
- Arrival passage, entry level 4, exit level 0, inside 0, dir=0:
  - incr high until inside==4, then gateCtrl pulse;
  - arrivGate=1, poundOccupied=1, then close pulse;
  - decr high until 0, open/close pulses on deptGate;
  - done pulses once, busy falls the next cycle.
- dir=1 with levels swapped -> deptGate is the entry gate and sequence order mirrors the arrival case; incr and decr never both high.
- Inside already at entry level on accept -> no incr/decr; gateCtrl pulses the cycle after PREP.
- Gate status held at 0 after OPEN_IN pulse -> fault=1 exactly GATE_TIMEOUT=8 cycles later; outputs quiesced; reset clears it.
- Assert req in WAIT_IN, then reset mid-ADJ -> the second req is ignored; after reset state=IDLE and outputs 0. With LOCK_SEQ_PASS_CNT_EN, passCount goes 0->2 after two passages and wraps after 256.
